axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
AXI4 slave (responder) that backs an on-chip word-addressed SRAM. It is the target end for the a23 core's AXI4 master: it services single-beat core reads and writes, and 4-beat WRAP cache-line fills. Read and write channels run independently. Each channel has one transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits
DATA_WIDTH, 32, data width in bits; fixed at 32, so WSTRB is 4 bits
ID_WIDTH, 4, width of AWID/ARID/BID/RID
MEM_WORDS, 4096, SRAM depth in words; valid byte addresses are 0 .. MEM_WORDS*4-1
BASE_ADDR, 32'h0, byte address that maps to word 0

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst_n  in  1  reset, asynchronous assert, active-low
slave  axi4_if.slave  -  AXI4 slave modport. Signals used: AW{VALID,READY,ADDR,LEN,SIZE,BURST,ID}, W{VALID,READY,DATA,STRB,LAST}, B{VALID,READY,RESP,ID}, AR{VALID,READY,ADDR,LEN,SIZE,BURST,ID}, R{VALID,READY,DATA,RESP,LAST,ID}

Behaviour:
- Reset (i_rst_n=0): both FSMs go to IDLE.
  - AWREADY=ARREADY=1.
  - WREADY=BVALID=RVALID=RLAST=0; RDATA=0; BRESP=RRESP=0.
  - Any in-flight burst is dropped with no response. SRAM contents are not reset.
- Word index = (addr-BASE_ADDR)>>2. An address is out-of-range if the index is >= MEM_WORDS or addr < BASE_ADDR.
- Read FSM, RD_IDLE -> RD_DATA -> RD_IDLE:
  - RD_IDLE: ARREADY=1. On ARVALID, capture addr, len, burst and id, clear beat_cnt, then go to RD_DATA.
  - RD_DATA: ARREADY=0, RVALID=1.
    - RDATA = mem[idx]; it is 0 when out-of-range.
    - RRESP = 2'b00 OKAY, or 2'b10 SLVERR when out-of-range.
    - RID = captured id. RLAST = (beat_cnt==len).
  - On RVALID&RREADY: advance the address, increment beat_cnt. If RLAST, go to RD_IDLE, with ARREADY=1 on the next cycle.
  - Latency: AR handshake in cycle N gives RVALID in cycle N+1. RDATA is held stable while RREADY=0.
- Write FSM, WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE:
  - WR_IDLE: AWREADY=1. On AWVALID, capture addr, len, burst and id, then go to WR_DATA.
  - WR_DATA: WREADY=1. On WVALID&WREADY, write each byte lane whose WSTRB bit is set; out-of-range writes are discarded. Then advance the address and increment beat_cnt.
    - Leave for WR_RESP when beat_cnt==len.
    - An error flag is set if WLAST disagrees with (beat_cnt==len), or if any beat was out-of-range.
  - WR_RESP: BVALID=1, BID=id, BRESP = SLVERR if the error flag is set, else OKAY. Hold until BREADY, then go to WR_IDLE.
- Address advance, in 4-byte steps (AxSIZE is assumed 2; any other value forces SLVERR, and the address still steps by 4):
  - FIXED (2'b00): the address is unchanged.
  - INCR (2'b01), and reserved 2'b11: addr += 4.
  - WRAP (2'b10):
    - Wrap span = (len+1)*4 bytes; len must be 1, 3, 7 or 15, otherwise the burst is treated as INCR.
    - Low address bits within the span increment modulo the span. Example: start 0x1C with len=3 gives 0x1C, 0x10, 0x14, 0x18.
- Simultaneous read and write to the same word:
  - Write commits at the clock edge. An RDATA beat presented in the same cycle shows the old value; the next beat shows the new one.
  - No ordering is guaranteed between the channels.
- An AW request accepted while a read burst is active, or the reverse, is serviced in parallel.

Optional Feature:
AXI4_SRAM_SLAVE_RD_PIPE_EN.
- Defined: RDATA is registered from the SRAM. An extra state RD_FETCH sits between RD_IDLE and RD_DATA.
  - AR handshake in cycle N gives RVALID in cycle N+2.
  - Each subsequent beat costs 2 cycles, with RVALID low for one cycle between beats.
- Undefined: combinational read and the latency described in Behaviour.

Test Plan:
- Single write then read: AW 0x40, W 0xDEADBEEF with STRB=4'hF, then AR 0x40 len=0 -> BRESP=OKAY; RDATA=0xDEADBEEF, RLAST=1, RVALID in the cycle after the AR handshake.
- Byte strobes: preload 0x11223344 at 0x80; write 0xAABBCCDD with STRB=4'b0101; read back -> 0x11BB33DD.
- WRAP fill: preload words 0x10..0x1C = 1, 2, 3, 4; AR 0x18 len=3 burst=WRAP -> RDATA 3, 4, 1, 2, with RLAST only on beat 4.
- Backpressure: during a WRAP read, hold RREADY=0 for 5 cycles on beat 2 -> RDATA and RLAST stay stable; total beats = 4. Same check for BREADY=0 -> BVALID held.
- Errors:
  - Write to MEM_WORDS*4 -> BRESP=SLVERR and memory is unchanged.
  - Read of the same address -> RDATA=0, RRESP=SLVERR.
  - INCR len=1 with WLAST=1 on beat 1 -> SLVERR.
- Reset mid-burst: deassert i_rst_n during beat 2 of a 4-beat read -> RVALID=0 asynchronously and ARREADY=1 after release; a new AR is serviced normally with memory intact.

Source files
------------

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle shared by the SRAM slave and whatever master drives it.
// The slave modport is the responder view; the master modport is the initiator view.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // Write address channel
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [ID_WIDTH-1:0]       awid;

    // Write data channel
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;

    // Write response channel
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic [ID_WIDTH-1:0]       bid;

    // Read address channel
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [ID_WIDTH-1:0]       arid;

    // Read data channel
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic [ID_WIDTH-1:0]       rid;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder in front of a word-addressed on-chip SRAM.
// Independent read and write channels, one outstanding burst per channel,
// FIXED / INCR / WRAP bursts of 32-bit beats.
// Optional build macro AXI4_SRAM_SLAVE_RD_PIPE_EN: registers read data out of
// the SRAM through an extra RD_FETCH state (two-cycle read beats).
module axi4_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    axi4_if.slave slave
);

    localparam int         IDX_W       = $clog2(MEM_WORDS);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    // Beat-to-beat address step; WRAP only wraps for legal spans, otherwise acts as INCR
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr + ADDR_WIDTH'(4);
        mask = {{(ADDR_WIDTH-10){1'b0}}, len, 2'b11};
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            next_addr = (addr & ~mask) | (inc & mask);
        end else begin
            next_addr = inc;
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    rd_state_t             rd_state;
    rd_state_t             rd_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic [1:0]            rd_burst;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [7:0]            rd_beat;
    logic                  rd_size_err;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_beat_data;
    logic                  ar_ready;
    logic                  r_valid;

    wr_state_t             wr_state;
    wr_state_t             wr_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic [1:0]            wr_burst;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [7:0]            wr_beat;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] wr_off;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_in_range;
    logic                  wr_last;
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;

    // Address decode: word index relative to BASE_ADDR, range-checked on both ends
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_idx      = rd_off[IDX_W+1:2];
    assign rd_in_range = (rd_addr >= BASE_ADDR) && ((rd_off >> 2) < ADDR_WIDTH'(MEM_WORDS));
    assign rd_last     = (rd_beat == rd_len);
    assign rd_word     = rd_in_range ? mem[rd_idx] : '0;

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_idx      = wr_off[IDX_W+1:2];
    assign wr_in_range = (wr_addr >= BASE_ADDR) && ((wr_off >> 2) < ADDR_WIDTH'(MEM_WORDS));
    assign wr_last     = (wr_beat == wr_len);

    // Read FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // Read FSM next-state and channel handshake outputs
    always_comb begin
        rd_next  = rd_state;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                ar_ready = 1'b1;
                if (slave.arvalid) begin
`ifdef AXI4_SRAM_SLAVE_RD_PIPE_EN
                    rd_next = RD_FETCH;
`else
                    rd_next = RD_DATA;
`endif
                end
            end
            RD_FETCH: begin
                rd_next = RD_DATA;
            end
            RD_DATA: begin
                r_valid = 1'b1;
                if (slave.rready) begin
                    if (rd_last) begin
                        rd_next = RD_IDLE;
                    end else begin
`ifdef AXI4_SRAM_SLAVE_RD_PIPE_EN
                        rd_next = RD_FETCH;
`else
                        rd_next = RD_DATA;
`endif
                    end
                end
            end
            default: begin
                rd_next = RD_IDLE;
            end
        endcase
    end

    // Read burst bookkeeping: capture AR, then step address and beat count per accepted beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr     <= '0;
            rd_len      <= '0;
            rd_burst    <= '0;
            rd_id       <= '0;
            rd_beat     <= '0;
            rd_size_err <= 1'b0;
        end else if (rd_state == RD_IDLE && slave.arvalid) begin
            rd_addr     <= slave.araddr;
            rd_len      <= slave.arlen;
            rd_burst    <= slave.arburst;
            rd_id       <= slave.arid;
            rd_beat     <= '0;
            rd_size_err <= (slave.arsize != SIZE_WORD);
        end else if (rd_state == RD_DATA && slave.rready) begin
            rd_addr     <= next_addr(rd_addr, rd_len, rd_burst);
            rd_beat     <= rd_beat + 8'd1;
        end
    end

`ifdef AXI4_SRAM_SLAVE_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered SRAM read; loaded during RD_FETCH and held through RD_DATA
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else if (rd_state == RD_FETCH) begin
            rdata_q <= rd_word;
        end
    end

    assign rd_beat_data = rdata_q;
`else
    assign rd_beat_data = rd_word;
`endif

    assign slave.arready = ar_ready;
    assign slave.rvalid  = r_valid;
    assign slave.rdata   = r_valid ? rd_beat_data : '0;
    assign slave.rresp   = (r_valid && (!rd_in_range || rd_size_err)) ? RESP_SLVERR : RESP_OKAY;
    assign slave.rlast   = r_valid && rd_last;
    assign slave.rid     = rd_id;

    // Write FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Write FSM next-state and channel handshake outputs
    always_comb begin
        wr_next  = wr_state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                aw_ready = 1'b1;
                if (slave.awvalid) begin
                    wr_next = WR_DATA;
                end
            end
            WR_DATA: begin
                w_ready = 1'b1;
                if (slave.wvalid && wr_last) begin
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                b_valid = 1'b1;
                if (slave.bready) begin
                    wr_next = WR_IDLE;
                end
            end
            default: begin
                wr_next = WR_IDLE;
            end
        endcase
    end

    // Write burst bookkeeping; the error flag accumulates WLAST misplacement and range faults
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_burst <= '0;
            wr_id    <= '0;
            wr_beat  <= '0;
            wr_err   <= 1'b0;
        end else if (wr_state == WR_IDLE && slave.awvalid) begin
            wr_addr  <= slave.awaddr;
            wr_len   <= slave.awlen;
            wr_burst <= slave.awburst;
            wr_id    <= slave.awid;
            wr_beat  <= '0;
            wr_err   <= (slave.awsize != SIZE_WORD);
        end else if (wr_state == WR_DATA && slave.wvalid) begin
            wr_addr  <= next_addr(wr_addr, wr_len, wr_burst);
            wr_beat  <= wr_beat + 8'd1;
            wr_err   <= wr_err || (slave.wlast != wr_last) || !wr_in_range;
        end
    end

    // SRAM byte-lane write port; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (wr_state == WR_DATA && slave.wvalid && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (slave.wstrb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= slave.wdata[b*8 +: 8];
                end
            end
        end
    end

    assign slave.awready = aw_ready;
    assign slave.wready  = w_ready;
    assign slave.bvalid  = b_valid;
    assign slave.bresp   = (b_valid && wr_err) ? RESP_SLVERR : RESP_OKAY;
    assign slave.bid     = wr_id;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: stimulus tasks queue expected R/B
// responses, monitors pop and compare on every R and B handshake.
module tb_axi4_sram_slave;

    localparam int         MEM_WORDS   = 4096;
    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] SLVERR      = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    r_exp_t rd_q[$];
    b_exp_t wr_q[$];
    int     total  = 0;
    int     bad    = 0;
    int     r_seen = 0;
    int     b_seen = 0;

    always #5 clk = ~clk;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .MEM_WORDS  (MEM_WORDS),
        .BASE_ADDR  (32'h0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .slave   (bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last, input logic [3:0] id);
        r_exp_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        e.id   = id;
        rd_q.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
        b_exp_t e;
        e.resp = resp;
        e.id   = id;
        wr_q.push_back(e);
    endtask

    // Read data monitor: every accepted beat must match the head of the read queue
    always @(negedge clk) begin : r_monitor
        r_exp_t e;
        if (rst_n && bus.rvalid && bus.rready) begin
            r_seen++;
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL r_unexpected: got beat 0x%08h expected none", bus.rdata);
            end else begin
                e = rd_q.pop_front();
                check_output("rdata", bus.rdata, e.data);
                check_output("rresp", 32'(bus.rresp), 32'(e.resp));
                check_output("rlast", 32'(bus.rlast), 32'(e.last));
                check_output("rid", 32'(bus.rid), 32'(e.id));
            end
        end
    end

    // Write response monitor: every accepted B must match the head of the write queue
    always @(negedge clk) begin : b_monitor
        b_exp_t e;
        if (rst_n && bus.bvalid && bus.bready) begin
            b_seen++;
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL b_unexpected: got bresp %0d expected none", bus.bresp);
            end else begin
                e = wr_q.pop_front();
                check_output("bresp", 32'(bus.bresp), 32'(e.resp));
                check_output("bid", 32'(bus.bid), 32'(e.id));
            end
        end
    end

    // Write burst: data beat i carries base+i; early_idx forces WLAST on that beat too
    task automatic apply_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [3:0] id, input logic [31:0] base, input logic [3:0] strb,
                               input int early_idx);
        int n;
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = 3'd2;
        bus.awburst = burst;
        bus.awid    = id;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
        if (!bus.awready) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = base + 32'(i);
            bus.wstrb  = strb;
            bus.wlast  = (i == int'(len)) || (i == early_idx);
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.wready && n < 50);
            if (!bus.wready) timeout_fail("w_handshake");
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    // Read request; also checks the first beat appears at the documented latency
    task automatic apply_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [2:0] size, input logic [3:0] id);
        int n;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arid    = id;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
        if (!bus.arready) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
`ifdef AXI4_SRAM_SLAVE_RD_PIPE_EN
        check_output("r_latency_gap", 32'(bus.rvalid), 32'd0);
        @(negedge clk);
`endif
        check_output("r_latency", 32'(bus.rvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            timeout_fail(name);
            rd_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic wait_rvalid(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 50);
        if (!bus.rvalid) timeout_fail(name);
    endtask

    // Directed test sequence
    initial begin : apply_stimulus
        int start_seen;
        int n;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2;
        bus.awburst = '0;   bus.awid = '0;
        bus.wvalid = 1'b0;  bus.wdata = '0;  bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
        bus.arburst = '0;   bus.arid = '0;
        bus.rready = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_arready", 32'(bus.arready), 32'd1);
        check_output("rst_awready", 32'(bus.awready), 32'd1);
        check_output("rst_wready", 32'(bus.wready), 32'd0);
        check_output("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check_output("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_output("rst_rlast", 32'(bus.rlast), 32'd0);
        check_output("rst_rdata", bus.rdata, 32'd0);
        check_output("rst_bresp", 32'(bus.bresp), 32'd0);
        check_output("rst_rresp", 32'(bus.rresp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single write then read");
        push_b(OKAY, 4'd3);
        apply_write(32'h40, 8'd0, BURST_INCR, 4'd3, 32'hDEADBEEF, 4'hF, -1);
        push_r(32'hDEADBEEF, OKAY, 1'b1, 4'd5);
        apply_read(32'h40, 8'd0, BURST_INCR, 3'd2, 4'd5);
        wait_drain("drain_single");

        $display("[TB] byte strobes");
        push_b(OKAY, 4'd1);
        apply_write(32'h80, 8'd0, BURST_INCR, 4'd1, 32'h11223344, 4'hF, -1);
        push_b(OKAY, 4'd1);
        apply_write(32'h80, 8'd0, BURST_INCR, 4'd1, 32'hAABBCCDD, 4'b0101, -1);
        push_r(32'h11BB33DD, OKAY, 1'b1, 4'd1);
        apply_read(32'h80, 8'd0, BURST_INCR, 3'd2, 4'd1);
        wait_drain("drain_strobe");

        $display("[TB] wrap fill");
        push_b(OKAY, 4'd2);
        apply_write(32'h10, 8'd3, BURST_INCR, 4'd2, 32'd1, 4'hF, -1);
        push_r(32'd3, OKAY, 1'b0, 4'd4);
        push_r(32'd4, OKAY, 1'b0, 4'd4);
        push_r(32'd1, OKAY, 1'b0, 4'd4);
        push_r(32'd2, OKAY, 1'b1, 4'd4);
        apply_read(32'h18, 8'd3, BURST_WRAP, 3'd2, 4'd4);
        wait_drain("drain_wrap");

        $display("[TB] read backpressure on beat 2");
        start_seen = r_seen;
        push_r(32'd3, OKAY, 1'b0, 4'd9);
        push_r(32'd4, OKAY, 1'b0, 4'd9);
        push_r(32'd1, OKAY, 1'b0, 4'd9);
        push_r(32'd2, OKAY, 1'b1, 4'd9);
        bus.rready = 1'b0;
        apply_read(32'h18, 8'd3, BURST_WRAP, 3'd2, 4'd9);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        wait_rvalid("bp_beat2_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check_output("bp_rvalid", 32'(bus.rvalid), 32'd1);
            check_output("bp_rdata", bus.rdata, 32'd4);
            check_output("bp_rlast", 32'(bus.rlast), 32'd0);
        end
        @(posedge clk); #1;
        bus.rready = 1'b1;
        wait_drain("drain_rbp");
        repeat (3) @(posedge clk);
        #1;
        check_output("bp_beat_count", 32'(r_seen - start_seen), 32'd4);

        $display("[TB] write response backpressure");
        start_seen = b_seen;
        push_b(OKAY, 4'd6);
        bus.bready = 1'b0;
        apply_write(32'h44, 8'd0, BURST_INCR, 4'd6, 32'h12345678, 4'hF, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 50);
        if (!bus.bvalid) timeout_fail("bp_bvalid_wait");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check_output("bp_bvalid", 32'(bus.bvalid), 32'd1);
            check_output("bp_bid", 32'(bus.bid), 32'd6);
        end
        @(posedge clk); #1;
        bus.bready = 1'b1;
        wait_drain("drain_bbp");
        check_output("bp_b_count", 32'(b_seen - start_seen), 32'd1);
        push_r(32'h12345678, OKAY, 1'b1, 4'd6);
        apply_read(32'h44, 8'd0, BURST_INCR, 3'd2, 4'd6);
        wait_drain("drain_bbp_read");

        $display("[TB] fixed burst and size error");
        push_r(32'hDEADBEEF, OKAY, 1'b0, 4'd3);
        push_r(32'hDEADBEEF, OKAY, 1'b1, 4'd3);
        apply_read(32'h40, 8'd1, BURST_FIXED, 3'd2, 4'd3);
        wait_drain("drain_fixed");
        push_r(32'hDEADBEEF, SLVERR, 1'b1, 4'd10);
        apply_read(32'h40, 8'd0, BURST_INCR, 3'd1, 4'd10);
        wait_drain("drain_size");

        $display("[TB] out-of-range access");
        push_b(OKAY, 4'd0);
        apply_write(32'h0, 8'd0, BURST_INCR, 4'd0, 32'hCAFEF00D, 4'hF, -1);
        push_b(SLVERR, 4'd11);
        apply_write(32'(MEM_WORDS * 4), 8'd0, BURST_INCR, 4'd11, 32'hFFFFFFFF, 4'hF, -1);
        push_r(32'h0, SLVERR, 1'b1, 4'd12);
        apply_read(32'(MEM_WORDS * 4), 8'd0, BURST_INCR, 3'd2, 4'd12);
        push_r(32'hCAFEF00D, OKAY, 1'b1, 4'd12);
        apply_read(32'h0, 8'd0, BURST_INCR, 3'd2, 4'd12);
        wait_drain("drain_oor");

        $display("[TB] early WLAST");
        push_b(SLVERR, 4'd13);
        apply_write(32'h60, 8'd1, BURST_INCR, 4'd13, 32'd5, 4'hF, 0);
        wait_drain("drain_wlast");

        $display("[TB] parallel read and write");
        push_b(OKAY, 4'd14);
        push_r(32'd2, OKAY, 1'b1, 4'd15);
        fork
            apply_write(32'h100, 8'd0, BURST_INCR, 4'd14, 32'h0BADF00D, 4'hF, -1);
            apply_read(32'h14, 8'd0, BURST_INCR, 3'd2, 4'd15);
        join
        wait_drain("drain_parallel");
        push_r(32'h0BADF00D, OKAY, 1'b1, 4'd15);
        apply_read(32'h100, 8'd0, BURST_INCR, 3'd2, 4'd15);
        wait_drain("drain_parallel_read");

        $display("[TB] reset mid-burst");
        push_r(32'd1, OKAY, 1'b0, 4'd7);
        bus.rready = 1'b0;
        apply_read(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd7);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        wait_rvalid("rst_beat2_valid");
        check_output("rst_beat2_data", bus.rdata, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_async_rvalid", 32'(bus.rvalid), 32'd0);
        check_output("rst_async_rlast", 32'(bus.rlast), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_release_arready", 32'(bus.arready), 32'd1);
        check_output("rst_release_rvalid", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        push_r(32'd3, OKAY, 1'b1, 4'd8);
        apply_read(32'h18, 8'd0, BURST_INCR, 3'd2, 4'd8);
        wait_drain("drain_after_reset");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so a stuck handshake can never hang the run
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
